// File: rtl/scan_select_sequencer.sv
// Select-code sequencer for a one-hot decoder: steps S through 0..7 at a
// programmable dwell rate and drives the decoder's blank (reset) input.
module scan_select_sequencer #(
  parameter int DWELL_W = 16,
  parameter int GUARD   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               step,
  output logic [2:0]         S,
  output logic               blank,
  output logic               tick,
  output logic               wrap
);

  localparam int GW = $clog2(GUARD + 2);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         s_q, s_d;
  logic [0:0]         dir_q, dir_d;
  logic [GW-1:0]      g_q, g_d;
  logic               step_q, step_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               blank_q, blank_d;

  logic               adv;
  logic               adv_eff;
  logic [2:0]         s_next;
  logic [0:0]         dir_next;
  logic               wrap_next;
  logic               guard_blank;

  always_comb begin
    adv     = enable ? (cnt_q >= dwell) : (step && !step_q);
    adv_eff = adv && (mode != MODE_HOLD);

    s_next    = s_q;
    dir_next  = DIR_UP;
    wrap_next = 1'b0;
    case (mode)
      MODE_UP: begin
        s_next    = s_q + 3'd1;
        wrap_next = (s_q == 3'd7);
      end
      MODE_DOWN: begin
        s_next    = s_q - 3'd1;
        wrap_next = (s_q == 3'd0);
      end
      MODE_PP: begin
        // Endpoints turn around without repeating; every 0->1 starts a new cycle.
        dir_next  = dir_q;
        wrap_next = (s_q == 3'd0);
        if (dir_q == DIR_UP) begin
          if (s_q == 3'd7) begin
            s_next   = 3'd6;
            dir_next = DIR_DOWN;
          end else begin
            s_next = s_q + 3'd1;
          end
        end else begin
          if (s_q == 3'd0) begin
            s_next   = 3'd1;
            dir_next = DIR_UP;
          end else begin
            s_next = s_q - 3'd1;
          end
        end
      end
      default: begin
        s_next    = s_q;
        wrap_next = 1'b0;
      end
    endcase

    // Counter keeps running in hold-blank mode; it only freezes when paused.
    cnt_d  = enable ? (adv ? '0 : cnt_q + DWELL_W'(1)) : cnt_q;
    step_d = step;
    s_d    = adv_eff ? s_next : s_q;
    dir_d  = (mode != MODE_PP) ? DIR_UP : (adv_eff ? dir_next : dir_q);
    tick_d = adv_eff;
    wrap_d = adv_eff && wrap_next;

    // g_q counts blank cycles still owed, including the one currently shown.
    if (adv_eff) begin
      g_d         = GUARD_INIT;
      guard_blank = (GUARD > 0);
    end else if (g_q > GW'(1)) begin
      g_d         = g_q - GW'(1);
      guard_blank = 1'b1;
    end else begin
      g_d         = '0;
      guard_blank = 1'b0;
    end
    blank_d = (mode == MODE_HOLD) || guard_blank;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      s_q     <= 3'd0;
      dir_q   <= DIR_UP;
      g_q     <= GUARD_INIT;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      dir_q   <= dir_d;
      g_q     <= g_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      blank_q <= blank_d;
    end
  end

  assign S     = s_q;
  assign blank = blank_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed bench for scan_select_sequencer (DWELL_W=16, GUARD=1).
module tb_scan_select_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] dwell;
  logic        step;
  logic [2:0]  S;
  logic        blank;
  logic        tick;
  logic        wrap;

  int total;
  int bad;

  scan_select_sequencer #(.DWELL_W(16), .GUARD(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .dwell  (dwell),
    .step   (step),
    .S      (S),
    .blank  (blank),
    .tick   (tick),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] s_e, input logic tick_e,
                           input logic wrap_e, input logic blank_e);
    check({tag, ".S"},     {5'd0, S},     {5'd0, s_e});
    check({tag, ".tick"},  {7'd0, tick},  {7'd0, tick_e});
    check({tag, ".wrap"},  {7'd0, wrap},  {7'd0, wrap_e});
    check({tag, ".blank"}, {7'd0, blank}, {7'd0, blank_e});
  endtask

  int pp_seq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int dn_seq[3]  = '{1, 0, 7};

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    enable = 1'b1;
    mode   = 2'b00;
    dwell  = 16'd3;
    step   = 1'b0;

    // Reset state
    cyc();
    cyc();
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b1);

    // Up count, dwell=3: change every 4 cycles, wrap only on 7->0
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        check_out("up_dwell", 3'((k - 1) % 8), 1'b0, 1'b0, 1'b0);
      end
      cyc();
      check_out("up_change", 3'(k % 8), 1'b1, (k == 8), 1'b1);
    end

    // Ping-pong, dwell=0: endpoints never repeated, wrap on 0->1
    mode  = 2'b10;
    dwell = 16'd0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      check_out("pingpong", 3'(pp_seq[i]), 1'b1, (i == 0 || i == 14), 1'b1);
    end
    cyc();
    check_out("pp_to2", 3'd2, 1'b1, 1'b0, 1'b1);

    // Down from S=2, dwell=1: 1,0,7 with wrap on 0->7
    mode  = 2'b01;
    dwell = 16'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_out("down_dwell", (i == 0) ? 3'd2 : 3'(dn_seq[i - 1]), 1'b0, 1'b0, 1'b0);
      cyc();
      check_out("down_change", 3'(dn_seq[i]), 1'b1, (i == 2), 1'b1);
    end

    // Hold-blank entered mid-dwell
    cyc();
    check_out("down_mid", 3'd7, 1'b0, 1'b0, 1'b0);
    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_out("hold", 3'd7, 1'b0, 1'b0, 1'b1);
    end

    // Paused: step held 5 cycles counts once, then two pulses
    mode   = 2'b00;
    enable = 1'b0;
    cyc();
    check_out("pause_idle", 3'd7, 1'b0, 1'b0, 1'b0);
    step = 1'b1;
    cyc();
    check_out("step_held0", 3'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_out("step_held", 3'd0, 1'b0, 1'b0, 1'b0);
    end
    for (int p = 1; p <= 2; p++) begin
      step = 1'b0;
      cyc();
      check_out("step_low", 3'(p - 1), 1'b0, 1'b0, 1'b0);
      step = 1'b1;
      cyc();
      check_out("step_pulse", 3'(p), 1'b1, 1'b0, 1'b1);
    end

    // Re-enable: frozen cnt=1 with dwell=1 advances at once; step ignored
    enable = 1'b1;
    cyc();
    check_out("resume", 3'd3, 1'b1, 1'b0, 1'b1);
    cyc();
    check_out("step_ign_a", 3'd3, 1'b0, 1'b0, 1'b0);
    step = 1'b0;
    cyc();
    check_out("resume_adv", 3'd4, 1'b1, 1'b0, 1'b1);
    step = 1'b1;
    cyc();
    check_out("step_ign_b", 3'd4, 1'b0, 1'b0, 1'b0);

    // Dwell lowered below running count: advance at next compare, then period 11
    step  = 1'b0;
    dwell = 16'd100;
    repeat (49) cyc();
    check_out("dwell100", 3'd4, 1'b0, 1'b0, 1'b0);
    dwell = 16'd10;
    cyc();
    check_out("dwell_drop", 3'd5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_out("dwell10_wait", 3'd5, 1'b0, 1'b0, 1'b0);
    end
    cyc();
    check_out("dwell10_adv", 3'd6, 1'b1, 1'b0, 1'b1);

    // Reset during ping-pong descent
    mode  = 2'b10;
    dwell = 16'd0;
    cyc();
    check_out("pp2_7", 3'd7, 1'b1, 1'b0, 1'b1);
    cyc();
    check_out("pp2_6", 3'd6, 1'b1, 1'b0, 1'b1);
    cyc();
    check_out("pp2_5", 3'd5, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    cyc();
    check_out("mid_reset", 3'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc();
    check_out("restart_1", 3'd1, 1'b1, 1'b1, 1'b1);
    cyc();
    check_out("restart_2", 3'd2, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
